// File: rtl/mealy_non_1011_pkg.sv
// Shared types and constants for the non-overlapping "1011" Mealy detector.
// Optional detection counter is enabled with the MEALY_NON_1011_CNT_EN macro.
package mealy_non_1011_pkg;

    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2,
        S3 = 2'd3
    } state_t;

    // Serial pattern, MSB is the first bit received.
    localparam logic [3:0] PATTERN = 4'b1011;

endpackage

// File: rtl/mealy_non_1011_cnt.sv
// Saturating event counter with synchronous active-high reset.
// Only instantiated when MEALY_NON_1011_CNT_EN is defined.
module mealy_non_1011_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mealy_non_1011.sv
// Non-overlapping Mealy detector for the serial pattern "1011" (first bit first).
// Define MEALY_NON_1011_CNT_EN to add the saturating det_count output.
module mealy_non_1011
    import mealy_non_1011_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in,
`ifdef MEALY_NON_1011_CNT_EN
    output logic [CNT_W-1:0] det_count,
`endif
    output logic             out
);

    state_t state;
    state_t next_state;

    if ((CNT_W < 1) || (CNT_W > 32)) begin : g_cnt_w_check
        $error("CNT_W must be in 1..32");
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S0;
        end else begin
            state <= next_state;
        end
    end

    // A completed match returns to S0 so none of its bits start the next match.
    always_comb begin
        next_state = S0;
        out        = 1'b0;
        case (state)
            S0: next_state = (in == PATTERN[3]) ? S1 : S0;
            S1: next_state = (in == PATTERN[2]) ? S2 : S1;
            S2: next_state = (in == PATTERN[1]) ? S3 : S0;
            S3: begin
                if (in == PATTERN[0]) begin
                    next_state = S0;
                    out        = 1'b1;
                end else begin
                    next_state = S2;
                end
            end
            default: begin
                next_state = S0;
                out        = 1'b0;
            end
        endcase
        if (rst) begin
            out = 1'b0;
        end
    end

`ifdef MEALY_NON_1011_CNT_EN
    mealy_non_1011_cnt #(
        .CNT_W(CNT_W)
    ) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (out),
        .count(det_count)
    );
`endif

endmodule

// File: tb/tb_mealy_non_1011.sv
// Testbench for mealy_non_1011: directed vector table, hand sequences and a
// random stream checked against a bit-history model; det_count under MEALY_NON_1011_CNT_EN.
module tb_mealy_non_1011;

    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in  = 1'b0;
    logic out;
`ifdef MEALY_NON_1011_CNT_EN
    logic [CNT_W-1:0] det_count;
`endif

    int errors = 0;
    int checks = 0;

    // Model: bits received since the last reset or completed match (last 3 kept).
    bit model_hist[$];
    int model_cnt = 0;

    typedef struct {
        logic rst;
        logic in;
        logic exp_out;
    } vec_t;
    vec_t vecs[$];

    mealy_non_1011 #(
        .CNT_W(CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in       (in),
`ifdef MEALY_NON_1011_CNT_EN
        .det_count(det_count),
`endif
        .out      (out)
    );

    always #5 clk = ~clk;

    function automatic logic model_out(input logic r, input logic b);
        int n;
        n = model_hist.size();
        if (r) return 1'b0;
        if (n >= 3 && model_hist[n-3] == 1'b1 && model_hist[n-2] == 1'b0 &&
            model_hist[n-1] == 1'b1 && b == 1'b1)
            return 1'b1;
        return 1'b0;
    endfunction

    function automatic void model_step(input logic r, input logic b);
        if (r) begin
            model_hist.delete();
            model_cnt = 0;
        end else if (model_out(r, b)) begin
            model_hist.delete();
            if (model_cnt < CNT_MAX) model_cnt++;
        end else begin
            model_hist.push_back(b);
            if (model_hist.size() > 3) void'(model_hist.pop_front());
        end
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Drives one bit, checks out against the model mid-cycle, then clocks it in.
    task automatic applyStimulus(input logic r, input logic b, input string name,
                                 output logic sampled);
        @(negedge clk);
        rst = r;
        in  = b;
        #1;
        sampled = out;
        checkOutput({name, " out"}, int'(out), int'(model_out(r, b)));
        @(posedge clk);
        model_step(r, b);
        #1;
`ifdef MEALY_NON_1011_CNT_EN
        checkOutput({name, " det_count"}, int'(det_count), model_cnt);
`endif
    endtask

    function automatic void add(input logic r, input logic b, input logic e);
        vec_t v;
        v.rst = r;
        v.in = b;
        v.exp_out = e;
        vecs.push_back(v);
    endfunction

    function automatic void add_seq(input string bits, input string outs);
        for (int i = 0; i < bits.len(); i++)
            add(1'b0, bits[i] == "1", outs[i] == "1");
    endfunction

    initial begin
        logic s;

        // Reset and basic detect, then continuation ending in S1.
        add(1'b1, 1'b0, 1'b0);
        add_seq("1011", "0001");
        add_seq("01011", "00001");
        add_seq("011", "000");
        // Non-overlap: 1011011 yields one pulse.
        add(1'b1, 1'b1, 1'b0);
        add_seq("1011011", "0001000");
        // S3 with 0 falls back to S2.
        add(1'b1, 1'b0, 1'b0);
        add_seq("101011", "000001");
        // Back-to-back matches: 10111011 yields two pulses.
        add(1'b1, 1'b0, 1'b0);
        add_seq("10111011", "00010001");
        // Reset mid-pattern (in S3 with in=1) discards the partial match.
        add(1'b1, 1'b0, 1'b0);
        add_seq("101", "000");
        add(1'b1, 1'b1, 1'b0);
        add_seq("1", "0");
        add_seq("011", "001");

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].rst, vecs[i].in, $sformatf("vec%0d", i), s);
            checkOutput($sformatf("vec%0d table", i), int'(s), int'(vecs[i].exp_out));
        end

`ifdef MEALY_NON_1011_CNT_EN
        begin
            int exp_cnt[5] = '{1, 2, 3, 3, 3};
            applyStimulus(1'b1, 1'b0, "cnt reset", s);
            checkOutput("cnt after reset", int'(det_count), 0);
            for (int k = 0; k < 5; k++) begin
                applyStimulus(1'b0, 1'b1, "cnt seq", s);
                applyStimulus(1'b0, 1'b0, "cnt seq", s);
                applyStimulus(1'b0, 1'b1, "cnt seq", s);
                applyStimulus(1'b0, 1'b1, "cnt seq", s);
                checkOutput($sformatf("cnt detect%0d", k + 1), int'(det_count), exp_cnt[k]);
            end
            applyStimulus(1'b1, 1'b1, "cnt clear", s);
            checkOutput("cnt cleared", int'(det_count), 0);
        end
`endif

        applyStimulus(1'b1, 1'b0, "rand reset", s);
        for (int i = 0; i < 600; i++) begin
            logic r;
            logic b;
            r = ($urandom_range(0, 39) == 0);
            b = ($urandom_range(0, 2) != 0);
            applyStimulus(r, b, $sformatf("rand%0d", i), s);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mealy_non_1011.md
MEALY_NON_1011 -- requirements
Module: mealy_non_1011

Interface
REQ-001 Parameter: CNT_W, 8, width of the detection counter (used only when MEALY_NON_1011_CNT_EN is defined); legal range 1..32.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous and active-high.
REQ-004 Port: in  input  1  serial data bit, sampled on each rising clk edge.
REQ-005 Port: out  output  1  Mealy detect flag; high in the cycle whose sampled bit completes "1011".
REQ-006 Port: det_count  output  CNT_W  saturating count of detections; present only when MEALY_NON_1011_CNT_EN is defined.

Function
REQ-007 The block SHALL detect the serial pattern 1,0,1,1 (first bit received first) in non-overlapping mode: bits of a completed match are never reused.
REQ-008 The FSM SHALL have exactly four states: S0 idle, S1 seen "1", S2 seen "10", S3 seen "101".
REQ-009 Transitions: S0 in=0->S0, in=1->S1; S1 in=0->S2, in=1->S1; S2 in=0->S0, in=1->S3; S3 in=0->S2, in=1->S0.
REQ-010 out SHALL equal (state==S3 && in==1) combinationally, with zero-cycle latency relative to the completing bit; out is 0 in all other cases.
REQ-011 After a detection the FSM SHALL return to S0, so "1011011" yields exactly one detection, while "10111011" yields two.
REQ-012 out SHALL be forced to 0 while rst is high, regardless of state or in.
REQ-013 An X/unknown-free design: the unused state encoding has no encoding; the default branch of the next-state logic SHALL go to S0 with out=0.

Reset
REQ-014 On a rising clk edge with rst=1 the state SHALL become S0 (and det_count 0 when enabled); rst has priority over in.
REQ-015 Reset asserted mid-pattern (e.g. in S3) SHALL discard the partial match; the first post-reset detection requires a complete new "1011".
REQ-016 No asynchronous reset path SHALL exist.

Configuration
REQ-017 Macro MEALY_NON_1011_CNT_EN: when defined, det_count exists and increments by 1 on every rising edge where out=1 and rst=0, saturating at 2^CNT_W-1; when undefined, det_count and its logic are absent and all other behaviour is identical.

Structure
REQ-018 A shared package mealy_non_1011_pkg SHALL hold the state enum type (2-bit: S0=2'd0, S1=2'd1, S2=2'd2, S3=2'd3) and the pattern constant 4'b1011.
REQ-019 The saturating counter SHALL be a separate sub-module mealy_non_1011_cnt (inputs clk, rst, inc; output count of CNT_W bits), instantiated only under MEALY_NON_1011_CNT_EN.

Verification
REQ-020 Reset for one edge, then in=1,0,1,1 on successive edges -> out=1 only during the 4th bit; state S0 afterward.
REQ-021 Continue in=0,1,0,1,1 -> out=1 only during the last bit; then in=0,1,1 -> out stays 0 (ends in S1).
REQ-022 Stream 1,0,1,1,0,1,1 -> exactly one out pulse (bit 4); non-overlap confirmed.
REQ-023 Stream 1,0,1,0,1,1 -> out=1 on bit 6 (S3 in=0 returns to S2).
REQ-024 Feed 1,0,1 then assert rst for one edge, then 1 -> no out pulse; out=0 throughout reset.
REQ-025 With MEALY_NON_1011_CNT_EN and CNT_W=2, drive five detections -> det_count reads 1,2,3,3,3; rst returns it to 0.
